// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/load-store memory arbiter: FSM states,
// requester identifiers, mem_len codes and the fixed fetch length.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    localparam logic [1:0] LEN_1B = 2'd0;
    localparam logic [1:0] LEN_2B = 2'd1;
    localparam logic [1:0] LEN_4B = 2'd2;

    localparam logic [2:0] FETCH_LEN = 3'd4;

    // Code 3 is an alias for a 4-byte access.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_1B:  return 3'd1;
            LEN_2B:  return 3'd2;
            LEN_4B:  return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port, byte-RAM port and busy flag.
// slave = arbiter side, master = requesters and RAM side.
interface mem_arbiter_if #(parameter int unsigned ADDR_W = 32);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              flush;
    logic              if_done;
    logic [31:0]       if_data;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_len;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, flush,
        output if_done, if_data,
        input  mem_req, mem_we, mem_addr, mem_len, mem_wdata,
        output mem_done, mem_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr, flush,
        input  if_done, if_data,
        output mem_req, mem_we, mem_addr, mem_len, mem_wdata,
        input  mem_done, mem_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_byte_seq.sv
// Byte sequencer: walks base..base+N-1 on the byte RAM, emits write bytes
// and assembles read bytes that return one cycle after their address.
module mem_byte_seq #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [2:0]        nbytes_i,
    input  logic              we_i,
    input  logic [31:0]       wdata_i,
    input  logic [7:0]        ram_rdata_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_wdata_o,
    output logic              fin_o,
    output logic [31:0]       rdata_o
);

    logic              active_q;
    logic [2:0]        cnt_q;
    logic [2:0]        cnt_d;
    logic [2:0]        n_q;
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ram_we_q;
    logic [7:0]        ram_wdata_q;
    logic [7:0]        wbyte;
    logic [1:0]        rd_idx;

    // cnt_q is the cycle index inside the transfer; reads finish one cycle
    // later than writes because the last byte lags its address.
    always_comb begin
        cnt_d  = cnt_q + 3'd1;
        rd_idx = cnt_q[1:0] - 2'd1;
        case (cnt_d[1:0])
            2'd0:    wbyte = wdata_q[7:0];
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            default: wbyte = wdata_q[31:24];
        endcase
        fin_o   = active_q & (cnt_q == (we_q ? n_q - 3'd1 : n_q));
        rdata_o = asm_q | ({24'd0, ram_rdata_i} << {rd_idx, 3'b000});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q    <= 1'b0;
            cnt_q       <= '0;
            n_q         <= '0;
            we_q        <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            addr_q      <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else if (start_i) begin
            active_q    <= 1'b1;
            cnt_q       <= '0;
            n_q         <= nbytes_i;
            we_q        <= we_i;
            base_q      <= base_i;
            wdata_q     <= wdata_i;
            asm_q       <= '0;
            addr_q      <= base_i;
            ram_we_q    <= we_i;
            ram_wdata_q <= we_i ? wdata_i[7:0] : '0;
        end else if (active_q) begin
            if (!we_q && cnt_q != 3'd0)
                asm_q[{rd_idx, 3'b000} +: 8] <= ram_rdata_i;
            if (abort_i || fin_o) begin
                active_q    <= 1'b0;
                addr_q      <= '0;
                ram_we_q    <= 1'b0;
                ram_wdata_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                if (cnt_d < n_q) begin
                    addr_q      <= base_q + ADDR_W'(cnt_d);
                    ram_we_q    <= we_q;
                    ram_wdata_q <= we_q ? wbyte : '0;
                end else begin
                    addr_q      <= '0;
                    ram_we_q    <= 1'b0;
                    ram_wdata_q <= '0;
                end
            end
        end
    end

    assign ram_addr_o  = addr_q;
    assign ram_we_o    = ram_we_q;
    assign ram_wdata_o = ram_wdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto a byte-wide RAM.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of MEM-first.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_e      state_q;
    src_e        src_q;
    logic        dir_we_q;
    logic        busy_q;
    logic        if_done_q;
    logic        mem_done_q;
    logic [31:0] if_data_q;
    logic [31:0] mem_rdata_q;
`ifdef MEM_ARB_RR_EN
    src_e        last_q;
`endif

    logic              if_ok;
    logic              mem_ok;
    logic              pick_mem;
    logic              grant;
    logic              abort;
    logic [ADDR_W-1:0] seq_base;
    logic [2:0]        seq_n;
    logic              seq_we;
    logic              seq_fin;
    logic [31:0]       seq_rdata;
    logic [ADDR_W-1:0] seq_ram_addr;
    logic              seq_ram_we;
    logic [7:0]        seq_ram_wdata;

    always_comb begin
        if_ok  = bus.if_req & ~bus.flush;
        mem_ok = bus.mem_req;
`ifdef MEM_ARB_RR_EN
        pick_mem = mem_ok & (~if_ok | (last_q == SRC_IF));
`else
        pick_mem = mem_ok;
`endif
        grant    = (state_q == ST_IDLE) & (mem_ok | if_ok);
        seq_base = pick_mem ? bus.mem_addr : bus.if_addr;
        seq_n    = pick_mem ? len_bytes(bus.mem_len) : FETCH_LEN;
        seq_we   = pick_mem & bus.mem_we;
        abort    = (state_q == ST_XFER) & (src_q == SRC_IF) & bus.flush;
    end

    mem_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
        .clk         (clk),
        .rst         (rst),
        .start_i     (grant),
        .abort_i     (abort),
        .base_i      (seq_base),
        .nbytes_i    (seq_n),
        .we_i        (seq_we),
        .wdata_i     (bus.mem_wdata),
        .ram_rdata_i (bus.ram_rdata),
        .ram_addr_o  (seq_ram_addr),
        .ram_we_o    (seq_ram_we),
        .ram_wdata_o (seq_ram_wdata),
        .fin_o       (seq_fin),
        .rdata_o     (seq_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_IF;
            dir_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q      <= SRC_IF;
`endif
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        state_q  <= ST_XFER;
                        busy_q   <= 1'b1;
                        src_q    <= pick_mem ? SRC_MEM : SRC_IF;
                        dir_we_q <= seq_we;
`ifdef MEM_ARB_RR_EN
                        last_q   <= pick_mem ? SRC_MEM : SRC_IF;
`endif
                    end
                end
                ST_XFER: begin
                    // A flush beats completion, even on the final capture cycle.
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (seq_fin) begin
                        state_q <= ST_DONE;
                        if (src_q == SRC_IF) begin
                            if_done_q <= 1'b1;
                            if_data_q <= seq_rdata;
                        end else begin
                            mem_done_q <= 1'b1;
                            if (!dir_we_q)
                                mem_rdata_q <= seq_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_done   = if_done_q;
    assign bus.if_data   = if_data_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.ram_addr  = seq_ram_addr;
    assign bus.ram_we    = seq_ram_we;
    assign bus.ram_wdata = seq_ram_wdata;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-timeline model and a shadow RAM.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [7:0] ram    [1024];
    logic [7:0] shadow [1024];

    always @(posedge clk) begin
        if (bus.ram_we === 1'b1)
            ram[bus.ram_addr[9:0]] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr[9:0]];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model: one transaction at a time, described by grant cycle, length,
    // direction and the cycle its done pulse is due.
    bit          started = 0;
    int          cyc = 0;
    bit          m_act = 0;
    int          m_t = 0;
    int          m_n = 0;
    int          m_end = 0;
    bit          m_src = 0;
    bit          m_we = 0;
    bit          m_last = 0;
    logic [31:0] m_base = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] if_data_exp = '0;
    logic [31:0] mem_rdata_exp = '0;

    function automatic logic [31:0] assemble(input logic [31:0] base, input int n);
        logic [31:0] r;
        logic [31:0] a;
        r = '0;
        for (int k = 0; k < n; k++) begin
            a = base + 32'(k);
            r = r | ({24'd0, shadow[a[9:0]]} << (8 * k));
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            int          rel;
            bit          e_we;
            bit          e_ifd;
            bit          e_md;
            bit          if_ok;
            bit          mem_ok;
            bit          pm;
            logic [31:0] e_addr;
            logic [7:0]  e_wd;
            rel = cyc - m_t;
            e_we = 0; e_ifd = 0; e_md = 0; e_addr = '0; e_wd = '0;
            if (m_act && rel >= 1 && rel <= m_n) begin
                e_addr = m_base + 32'(rel - 1);
                e_we   = m_we;
                e_wd   = m_we ? 8'(m_wdata >> (8 * (rel - 1))) : 8'h00;
            end
            if (m_act && rel == m_end) begin
                if (m_src) begin
                    e_md = 1;
                    if (!m_we) mem_rdata_exp = assemble(m_base, m_n);
                end else begin
                    e_ifd = 1;
                    if_data_exp = assemble(m_base, m_n);
                end
            end
            if (e_we) shadow[e_addr[9:0]] = e_wd;

            chk("busy",      64'(bus.busy),      64'(m_act));
            chk("if_done",   64'(bus.if_done),   64'(e_ifd));
            chk("mem_done",  64'(bus.mem_done),  64'(e_md));
            chk("if_data",   64'(bus.if_data),   64'(if_data_exp));
            chk("mem_rdata", 64'(bus.mem_rdata), 64'(mem_rdata_exp));
            chk("ram_addr",  64'(bus.ram_addr),  64'(e_addr));
            chk("ram_we",    64'(bus.ram_we),    64'(e_we));
            chk("ram_wdata", 64'(bus.ram_wdata), 64'(e_wd));

            if (rst) begin
                m_act = 0; m_last = 0;
                if_data_exp = '0; mem_rdata_exp = '0;
            end else if (m_act) begin
                if (!m_src && bus.flush && rel <= m_n + 1) m_act = 0;
                else if (rel == m_end) m_act = 0;
            end else begin
                if_ok  = bus.if_req && !bus.flush;
                mem_ok = bus.mem_req;
`ifdef MEM_ARB_RR_EN
                pm = mem_ok && (!if_ok || m_last == 0);
`else
                pm = mem_ok;
`endif
                if (if_ok || mem_ok) begin
                    m_act   = 1;
                    m_t     = cyc;
                    m_src   = pm;
                    m_last  = pm;
                    m_we    = pm && bus.mem_we;
                    m_base  = pm ? bus.mem_addr : bus.if_addr;
                    m_wdata = bus.mem_wdata;
                    m_n     = !pm ? 4 : (bus.mem_len == 2'd0) ? 1 : (bus.mem_len == 2'd1) ? 2 : 4;
                    m_end   = m_we ? m_n + 1 : m_n + 2;
                end
            end
        end
        cyc++;
    end

    task automatic poke(input int a, input logic [7:0] v);
        ram[a[9:0]] = v;
        shadow[a[9:0]] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rel = cycles from the current cycle to the done pulse, -1 on timeout.
    task automatic wait_done(input bit want_mem, output int rel);
        rel = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((want_mem ? bus.mem_done : bus.if_done) === 1'b1) begin
                rel = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.if_req = 0; bus.mem_req = 0; bus.flush = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic mem_go(input bit we, input logic [31:0] a, input logic [1:0] len, input logic [31:0] wd);
        bus.mem_req = 1; bus.mem_we = we; bus.mem_addr = a; bus.mem_len = len; bus.mem_wdata = wd;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom % 8 == 0) return 32'hFFFF_FFFC + ($urandom % 4);
        return 32'($urandom_range(0, 1023));
    endfunction

    initial begin
        int rel;
        int cnt;
        bit sd_if;
        bit sd_mem;
        bit prev_flush;
        logic [7:0] b;

        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = '0; bus.flush = 0;
        bus.mem_req = 0; bus.mem_we = 0; bus.mem_addr = '0; bus.mem_len = '0; bus.mem_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            b = 8'($urandom);
            ram[i] = b;
            shadow[i] = b;
        end
        tick();
        started = 1;
        tick();
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_ram_addr", 64'(bus.ram_addr), 64'd0);
        chk("reset_if_data", 64'(bus.if_data), 64'd0);
        rst = 1'b0;
        tick();

        // Fetch of a known instruction word
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
        bus.if_req = 1; bus.if_addr = 32'h100;
        wait_done(0, rel);
        chk("fetch_latency", 64'(rel), 64'd6);
        chk("fetch_data", 64'(bus.if_data), 64'h0010_0513);
        tick();
        bus.if_req = 0;
        chk("model_fetch_word", 64'(if_data_exp), 64'h0010_0513);

        // Simultaneous store and fetch: store wins, fetch follows DONE
        tick();
        mem_go(1, 32'h200, 2'd2, 32'hDEAD_BEEF);
        bus.if_req = 1; bus.if_addr = 32'h300;
        wait_done(1, rel);
        chk("store_latency", 64'(rel), 64'd5);
        tick();
        bus.mem_req = 0;
        chk("store_b0", 64'(ram[32'h200]), 64'hEF);
        chk("store_b1", 64'(ram[32'h201]), 64'hBE);
        chk("store_b2", 64'(ram[32'h202]), 64'hAD);
        chk("store_b3", 64'(ram[32'h203]), 64'hDE);
        wait_done(0, rel);
        chk("fetch_after_store", 64'(rel), 64'd6);
        tick();
        bus.if_req = 0;

        // Loads: 2 bytes, then 1 byte
        poke(7, 8'h34); poke(8, 8'h12); poke(32'h20, 8'hFF);
        tick();
        mem_go(0, 32'h7, 2'd1, '0);
        wait_done(1, rel);
        chk("load2_latency", 64'(rel), 64'd4);
        chk("load2_data", 64'(bus.mem_rdata), 64'h0000_1234);
        tick();
        bus.mem_req = 0;
        chk("model_load_half", 64'(mem_rdata_exp), 64'h0000_1234);
        tick();
        mem_go(0, 32'h20, 2'd0, '0);
        wait_done(1, rel);
        chk("load1_latency", 64'(rel), 64'd3);
        chk("load1_data", 64'(bus.mem_rdata), 64'h0000_00FF);
        tick();
        bus.mem_req = 0;

        // Flush two cycles into a fetch, then a clean fetch at 0x400
        tick();
        bus.if_req = 1; bus.if_addr = 32'h180;
        tick();
        tick();
        bus.flush = 1; bus.if_req = 0;
        tick();
        bus.flush = 0;
        chk("flush_busy_low", 64'(bus.busy), 64'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.if_done === 1'b1) cnt++;
        end
        chk("flush_no_done", 64'(cnt), 64'd0);
        poke(32'h400, 8'h93); poke(32'h401, 8'h00); poke(32'h402, 8'h10); poke(32'h403, 8'h00);
        tick();
        bus.if_req = 1; bus.if_addr = 32'h400;
        wait_done(0, rel);
        chk("refetch_latency", 64'(rel), 64'd6);
        chk("refetch_data", 64'(bus.if_data), 64'h0010_0093);
        tick();
        bus.if_req = 0;

        // Reset two bytes into a store
        for (int i = 0; i < 4; i++) poke(32'h280 + i, 8'h00);
        tick();
        mem_go(1, 32'h280, 2'd2, 32'h1122_3344);
        tick();
        tick();
        rst = 1'b1; bus.mem_req = 0;
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ram_we", 64'(bus.ram_we), 64'd0);
        chk("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
        chk("rst_ram_wdata", 64'(bus.ram_wdata), 64'd0);
        chk("rst_if_data", 64'(bus.if_data), 64'd0);
        chk("rst_mem_rdata", 64'(bus.mem_rdata), 64'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mem_done === 1'b1) cnt++;
        end
        chk("rst_no_done", 64'(cnt), 64'd0);
        chk("rst_b0", 64'(ram[32'h280]), 64'h44);
        chk("rst_b1", 64'(ram[32'h281]), 64'h33);
        chk("rst_b2", 64'(ram[32'h282]), 64'h00);
        chk("rst_b3", 64'(ram[32'h283]), 64'h00);

        // Randomized traffic
        tick();
        prev_flush = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sd_if = bus.if_done;
            sd_mem = bus.mem_done;
            tick();
            if (rst) begin
                rst = 0; bus.if_req = 0; bus.mem_req = 0;
            end else begin
                if (bus.if_req && (sd_if || prev_flush)) bus.if_req = 0;
                else if (!bus.if_req && $urandom % 3 == 0) begin
                    bus.if_req = 1; bus.if_addr = rand_addr();
                end
                if (bus.mem_req && sd_mem) bus.mem_req = 0;
                else if (!bus.mem_req && $urandom % 3 == 0)
                    mem_go(1'($urandom), rand_addr(), 2'($urandom), $urandom);
                if ($urandom % 300 == 0) rst = 1;
            end
            bus.flush = ($urandom % 12 == 0);
            prev_flush = bus.flush;
        end
        bus.flush = 0;
        do_reset();

`ifdef MEM_ARB_RR_EN
        begin
            bit order [4];
            int got;
            got = 0;
            mem_go(0, 32'h10, 2'd0, '0);
            bus.if_req = 1; bus.if_addr = 32'h40;
            for (int i = 0; i < 60 && got < 4; i++) begin
                @(negedge clk);
                if (bus.mem_done === 1'b1) begin order[got] = 1; got++; end
                else if (bus.if_done === 1'b1) begin order[got] = 0; got++; end
            end
            chk("rr_count", 64'(got), 64'd4);
            chk("rr_0_mem", 64'(order[0]), 64'd1);
            chk("rr_1_if",  64'(order[1]), 64'd0);
            chk("rr_2_mem", 64'(order[2]), 64'd1);
            chk("rr_3_if",  64'(order[3]), 64'd0);
            tick();
            bus.mem_req = 0; bus.if_req = 0;
        end
`endif

        repeat (12) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
